// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches pclk/data, frames 11-bit packets
// and folds E0/F0 prefixes into ext/brk flags on a single key-event strobe.
module ps2_scancode_rx #(
   parameter int unsigned FILTER_LEN  = 4,
   parameter int unsigned TIMEOUT_CYC = 20000
) (
   input  logic       CLKi,
   input  logic       RST,
   input  logic       pclk,
   input  logic       data,
   output logic [7:0] code,
   output logic       code_ext,
   output logic       code_brk,
   output logic       code_vld,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          pclk_s1, pclk_s2, data_s1, data_s2, pclk_f;
   logic [3:0]    flt_cnt;
   logic          fall;

   state_t        state, state_nx;
   logic [2:0]    bit_cnt, bit_cnt_nx;
   logic [7:0]    shreg, shreg_nx;
   logic          par, par_nx;
   logic [TW-1:0] tcnt, tcnt_nx;
   logic          ext_pend, ext_pend_nx, brk_pend, brk_pend_nx;
   logic [7:0]    code_nx;
   logic          code_ext_nx, code_brk_nx, code_vld_nx, frame_err_nx, busy_nx;

   always_ff @(posedge CLKi or posedge RST) begin
      if (RST) begin
         pclk_s1 <= 1'b1;
         pclk_s2 <= 1'b1;
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
         pclk_f  <= 1'b1;
         flt_cnt <= '0;
      end else begin
         pclk_s1 <= pclk;
         pclk_s2 <= pclk_s1;
         data_s1 <= data;
         data_s2 <= data_s1;
         if (pclk_s2 != pclk_f) begin
            if (flt_cnt == 4'(FILTER_LEN - 1)) begin
               pclk_f  <= pclk_s2;
               flt_cnt <= '0;
            end else begin
               flt_cnt <= flt_cnt + 4'd1;
            end
         end else begin
            flt_cnt <= '0;
         end
      end
   end

   // Fall event is decoded on the same edge that pclk_f is updated, so the FSM acts in step with it.
   assign fall = pclk_f && !pclk_s2 && (flt_cnt == 4'(FILTER_LEN - 1));

   always_ff @(posedge CLKi or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         par       <= 1'b0;
         tcnt      <= '0;
         ext_pend  <= 1'b0;
         brk_pend  <= 1'b0;
         code      <= '0;
         code_ext  <= 1'b0;
         code_brk  <= 1'b0;
         code_vld  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         bit_cnt   <= bit_cnt_nx;
         shreg     <= shreg_nx;
         par       <= par_nx;
         tcnt      <= tcnt_nx;
         ext_pend  <= ext_pend_nx;
         brk_pend  <= brk_pend_nx;
         code      <= code_nx;
         code_ext  <= code_ext_nx;
         code_brk  <= code_brk_nx;
         code_vld  <= code_vld_nx;
         frame_err <= frame_err_nx;
         busy      <= busy_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      bit_cnt_nx   = bit_cnt;
      shreg_nx     = shreg;
      par_nx       = par;
      tcnt_nx      = tcnt;
      ext_pend_nx  = ext_pend;
      brk_pend_nx  = brk_pend;
      code_nx      = code;
      code_ext_nx  = code_ext;
      code_brk_nx  = code_brk;
      code_vld_nx  = 1'b0;
      frame_err_nx = 1'b0;

      if (fall)
         tcnt_nx = '0;
      else if (state != IDLE)
         tcnt_nx = tcnt + TW'(1);

      if (fall) begin
         case (state)
            IDLE: begin
               if (!data_s2) begin
                  state_nx   = DATA;
                  bit_cnt_nx = '0;
               end
            end
            DATA: begin
               shreg_nx   = {data_s2, shreg[7:1]};
               bit_cnt_nx = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  state_nx = PARITY;
            end
            PARITY: begin
               par_nx   = data_s2;
               state_nx = STOP;
            end
            STOP: begin
               state_nx = IDLE;
               if (data_s2 && (^{shreg, par})) begin
                  if (shreg == 8'hE0) begin
                     ext_pend_nx = 1'b1;
                  end else if (shreg == 8'hF0) begin
                     brk_pend_nx = 1'b1;
                  end else begin
                     code_nx     = shreg;
                     code_ext_nx = ext_pend;
                     code_brk_nx = brk_pend;
                     code_vld_nx = 1'b1;
                     ext_pend_nx = 1'b0;
                     brk_pend_nx = 1'b0;
                  end
               end else begin
                  frame_err_nx = 1'b1;
                  ext_pend_nx  = 1'b0;
                  brk_pend_nx  = 1'b0;
               end
            end
            default: state_nx = IDLE;
         endcase
      end else if ((state != IDLE) && (tcnt == TW'(TIMEOUT_CYC - 1))) begin
         state_nx     = IDLE;
         tcnt_nx      = '0;
         frame_err_nx = 1'b1;
         ext_pend_nx  = 1'b0;
         brk_pend_nx  = 1'b0;
      end

      busy_nx = (state_nx != IDLE);
   end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: 100 MHz system clock, 1 us PS/2 clock period.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

   logic       CLKi = 1'b0;
   logic       RST;
   logic       pclk;
   logic       data;
   logic [7:0] code;
   logic       code_ext, code_brk, code_vld, frame_err, busy;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int vld_cnt  = 0;
   int err_cnt  = 0;
   int both_cnt = 0;
   int err_cyc  = 0;
   int fall_cyc = 0;
   int v0, e0;

   ps2_scancode_rx #(.FILTER_LEN(4), .TIMEOUT_CYC(20000)) dut (
      .CLKi(CLKi), .RST(RST), .pclk(pclk), .data(data),
      .code(code), .code_ext(code_ext), .code_brk(code_brk),
      .code_vld(code_vld), .frame_err(frame_err), .busy(busy)
   );

   always #5 CLKi = ~CLKi;

   always @(posedge CLKi) cyc <= cyc + 1;

   always @(negedge CLKi) begin
      if (code_vld) vld_cnt++;
      if (frame_err) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (code_vld && frame_err) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mark();
      v0 = vld_cnt;
      e0 = err_cnt;
   endtask

   task automatic send_bit(input logic b);
      data = b;
      #250;
      pclk = 1'b0;
      fall_cyc = cyc;
      #500;
      pclk = 1'b1;
      #250;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic flip);
      logic [10:0] f;
      f = {1'b1, ~(^b) ^ flip, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         send_bit(f[i]);
         if (i == 0) check("busy_mid_frame", busy, 1);
      end
      #1000;
   endtask

   initial begin
      RST  = 1'b1;
      pclk = 1'b1;
      data = 1'b1;
      #103;
      check("rst_code", code, 8'h00);
      check("rst_ext", code_ext, 0);
      check("rst_brk", code_brk, 0);
      check("rst_vld", code_vld, 0);
      check("rst_err", frame_err, 0);
      check("rst_busy", busy, 0);
      RST = 1'b0;
      #200;

      // plain make
      mark();
      send_frame(8'h1C, 1'b0);
      check("make_vld_n", vld_cnt - v0, 1);
      check("make_err_n", err_cnt - e0, 0);
      check("make_code", code, 8'h1C);
      check("make_ext", code_ext, 0);
      check("make_brk", code_brk, 0);
      check("make_busy_after", busy, 0);

      // break
      mark();
      send_frame(8'hF0, 1'b0);
      check("brk_prefix_vld_n", vld_cnt - v0, 0);
      send_frame(8'h1C, 1'b0);
      check("brk_vld_n", vld_cnt - v0, 1);
      check("brk_code", code, 8'h1C);
      check("brk_brk", code_brk, 1);
      check("brk_ext", code_ext, 0);

      // extended break
      mark();
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      check("ebrk_prefix_vld_n", vld_cnt - v0, 0);
      send_frame(8'h75, 1'b0);
      check("ebrk_vld_n", vld_cnt - v0, 1);
      check("ebrk_code", code, 8'h75);
      check("ebrk_ext", code_ext, 1);
      check("ebrk_brk", code_brk, 1);

      // parity error clears pending break, outputs held
      mark();
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b1);
      check("par_err_n", err_cnt - e0, 1);
      check("par_vld_n", vld_cnt - v0, 0);
      check("par_code_held", code, 8'h75);
      check("par_ext_held", code_ext, 1);
      send_frame(8'h1C, 1'b0);
      check("par_next_vld_n", vld_cnt - v0, 1);
      check("par_next_code", code, 8'h1C);
      check("par_next_brk", code_brk, 0);
      check("par_next_ext", code_ext, 0);

      // timeout, with start-edge latency check
      mark();
      data = 1'b0;
      #250;
      pclk = 1'b0;
      repeat (5) @(negedge CLKi);
      check("edge_delay_before", busy, 0);
      @(negedge CLKi);
      check("edge_delay_at", busy, 1);
      #443;
      pclk = 1'b1;
      #250;
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      check("to_busy_pending", busy, 1);
      #(20010 * 10);
      check("to_err_n", err_cnt - e0, 1);
      check("to_vld_n", vld_cnt - v0, 0);
      check("to_latency", err_cyc - fall_cyc, 20006);
      check("to_busy", busy, 0);
      send_frame(8'h1C, 1'b0);
      check("to_next_vld_n", vld_cnt - v0, 1);
      check("to_next_code", code, 8'h1C);
      check("to_next_err_n", err_cnt - e0, 1);

      // glitch shorter than filter
      mark();
      pclk = 1'b0;
      #30;
      pclk = 1'b1;
      #300;
      check("glitch_busy", busy, 0);
      check("glitch_err_n", err_cnt - e0, 0);
      check("glitch_vld_n", vld_cnt - v0, 0);

      // reset mid-frame
      send_frame(8'hF0, 1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      check("mid_busy", busy, 1);
      #100;
      RST = 1'b1;
      #1;
      check("mrst_code", code, 8'h00);
      check("mrst_ext", code_ext, 0);
      check("mrst_brk", code_brk, 0);
      check("mrst_vld", code_vld, 0);
      check("mrst_err", frame_err, 0);
      check("mrst_busy", busy, 0);
      #99;
      RST = 1'b0;
      pclk = 1'b1;
      data = 1'b1;
      #200;
      mark();
      send_frame(8'h1C, 1'b0);
      check("mrst_next_vld_n", vld_cnt - v0, 1);
      check("mrst_next_err_n", err_cnt - e0, 0);
      check("mrst_next_code", code, 8'h1C);
      check("mrst_next_brk", code_brk, 0);

      check("vld_err_overlap", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

PS/2 keyboard receiver that sits directly upstream of the MSX key-matrix stage. It synchronises and de-glitches the keyboard's `pclk`/`data` lines and frames the 11-bit PS/2 packets (start, 8 data LSB-first, odd parity, stop). It also folds the `E0` (extended) and `F0` (break) prefixes into flags and delivers one complete key event per strobe. The matrix stage consumes `code`/`code_ext`/`code_brk` on `code_vld` and never sees raw bytes.

## Interface
- `FILTER_LEN`, default 4: consecutive `CLKi` cycles a changed synchronised `pclk` level must persist before it is accepted (2..15).
- `TIMEOUT_CYC`, default 20000: `CLKi` cycles without a `pclk` falling edge, while mid-frame, before the frame is aborted (2 ms at 10 MHz).
- `CLKi`  in  1  system clock. One clock domain; all state is on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `pclk`  in  1  PS/2 clock from the keyboard. Asynchronous; idles high.
- `data`  in  1  PS/2 data from the keyboard. Asynchronous; idles high.
- `code`  out  8  scancode byte of the last event. Held until the next event.
- `code_ext`  out  1  event was preceded by `E0`. Held with `code`.
- `code_brk`  out  1  event was preceded by `F0` (key release). Held with `code`.
- `code_vld`  out  1  one-cycle strobe: `code`/`code_ext`/`code_brk` are new.
- `frame_err`  out  1  one-cycle strobe: frame discarded (bad start, parity, stop, or timeout).
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- **Input synchronisers:** `pclk` and `data` each pass through a 2-flop synchroniser. Both flops reset to 1.
- **Glitch filter:** filtered clock `pclk_f` resets to 1.
  - A mismatch counter increments on every cycle where synchronised `pclk` ≠ `pclk_f`. It clears on any matching cycle.
  - On the `FILTER_LEN`-th consecutive mismatching cycle, `pclk_f` takes the new level and the counter clears.
- **Fall event:** the cycle on which `pclk_f` goes 1→0. Synchronised `data` is sampled on that same edge. Rising edges are ignored.
- **State machine** (advances only on fall events):
  - IDLE: sampled 0 → DATA with bit count 0. Sampled 1 → stay in IDLE, no error.
  - DATA: shift the sampled bit into the byte, LSB first. After 8 bits → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: go to IDLE. Frame is good only if the stop bit is 1 AND (ones in data + parity) is odd.
- **Good frame, byte b:**
  - b = `E0`: set `ext_pend`. No strobe.
  - b = `F0`: set `brk_pend`. No strobe.
  - Any other b (including `E1`): `code`←b, `code_ext`←`ext_pend`, `code_brk`←`brk_pend`, pulse `code_vld`. Then clear both pending flags.
- **Bad frame:** pulse `frame_err`, clear both pending flags, output registers unchanged.
- **Timeout:**
  - A counter clears on every fall event and counts every cycle while state ≠ IDLE.
  - On reaching `TIMEOUT_CYC`: go to IDLE, pulse `frame_err`, clear both pending flags.
- **Simultaneous events:** a fall event and timeout expiry on the same cycle → the fall event wins and timeout is not taken.
- **Reset (including mid-frame):** state IDLE, all counters 0, pending flags 0. Outputs: `code`=8'h00, `code_ext`=0, `code_brk`=0, `code_vld`=0, `frame_err`=0, `busy`=0.

## Timing
- All outputs are registered.
- Edge delay: a `pclk` falling edge, held stable, is acted on at rising edge 2+`FILTER_LEN` after it is first captured (6 cycles at the default). `code_vld`/`frame_err` are visible from that edge for exactly one cycle.
- `busy` rises on the start-bit fall event and falls on the stop-bit fall event or on timeout.
- `code_vld` and `frame_err` are never high in the same cycle.
- Minimum supported PS/2 half-period is 2×(2+`FILTER_LEN`) `CLKi` cycles.
- `data` must be stable for the 2+`FILTER_LEN` cycles following a `pclk` fall.
- No back-pressure: the consumer must take each `code_vld` strobe. The next event is at least one frame (≥ 11 `pclk` periods) away.

## Test plan
- **Plain make:** after reset, send `1C` (parity 0, stop 1) at a 1 µs `pclk` period → exactly one `code_vld` with `code`=`1C`, `code_ext`=0, `code_brk`=0, `frame_err`=0. `busy` is high only during the frame.
- **Break:** send `F0` (parity 1), then `1C` → no strobe after `F0`. One `code_vld` with `code`=`1C`, `code_brk`=1, `code_ext`=0.
- **Extended break:** send `E0`, `F0`, `75` (parities 0, 1, 0) → one `code_vld` with `code`=`75`, `code_ext`=1, `code_brk`=1.
- **Parity error:** send `F0`, then `1C` with parity 1 → `frame_err` pulse, no `code_vld`. Then send a good `1C` → `code_brk`=0 (flag was cleared).
- **Timeout:** send the start bit plus 4 data bits, then idle `TIMEOUT_CYC`+10 cycles → one `frame_err` exactly `TIMEOUT_CYC` cycles after the last fall, `busy`=0. Then a full `1C` frame decodes correctly.
- **Glitch and reset:** in IDLE, drive a `pclk` low pulse of `FILTER_LEN`−1 cycles → no state change, `busy` stays 0. Assert `RST` mid-frame → all outputs 0 immediately, and the next full `1C` frame decodes correctly.
